// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: specifier/counter widths, hazard FSM
// encodings and the control-output bundle used by hazard_ctrl.
package cpu_pipe_pkg;

    localparam int unsigned REG_W_DEFAULT = 6;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned STATE_W       = 2;
    localparam int unsigned WAIT_W        = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b0,
                                         ifid_flush: 1'b0, idex_flush: 1'b0, pipe_hold: 1'b1};
    localparam hz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                        ifid_flush: 1'b1, idex_flush: 1'b1, pipe_hold: 1'b0};
    localparam hz_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0, pipe_hold: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// MEM-stage data-access handshake seen by the hazard controller.
interface hazard_ctrl_if;

    logic mem_req;
    logic mem_ready;

    modport master (output mem_req, output mem_ready);
    modport slave  (input  mem_req, input  mem_ready);

endinterface

// File: rtl/hz_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module hz_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout halt, taken-branch
// flush and load-use stall, plus stall/flush performance counters.
module hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEFAULT,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   Rs_ID,
    input  logic [REG_W-1:0]   Rt_ID,
    input  logic [REG_W-1:0]   Rt_EX,
    input  logic               MemRead_EX,
    input  logic               Branch_taken_EX,
    hazard_ctrl_if.slave       mem,
    output logic               PC_write,
    output logic               IFID_write,
    output logic               IDEX_bubble,
    output logic               IFID_flush,
    output logic               IDEX_flush,
    output logic               pipe_hold,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [STATE_W-1:0] state
);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              freeze;
    logic              load_use;
    hz_ctrl_t          ctrl;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = MemRead_EX && (Rt_EX != '0) && ((Rt_EX == Rs_ID) || (Rt_EX == Rt_ID));
    end

    // Next state; wait_q counts frozen cycles of the current outstanding access.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        freeze    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem.mem_req && !mem.mem_ready) begin
                    freeze = 1'b1;
                    wait_d = WAIT_W'(1);
                    if (MAX_WAIT <= 1) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem.mem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(MAX_WAIT)) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                freeze = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Output priority: reset/freeze > branch flush > load-use stall > idle.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (rst || freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (Branch_taken_EX) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            ctrl = CTRL_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    hz_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (!ctrl.pc_write),
        .cnt (stall_cnt)
    );

    hz_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (ctrl.ifid_flush),
        .cnt (flush_cnt)
    );

    assign PC_write    = ctrl.pc_write;
    assign IFID_write  = ctrl.ifid_write;
    assign IDEX_bubble = ctrl.idex_bubble;
    assign IFID_flush  = ctrl.ifid_flush;
    assign IDEX_flush  = ctrl.idex_flush;
    assign pipe_hold   = ctrl.pipe_hold;
    assign mem_timeout = timeout_q;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios, randomized traffic and
// counter saturation, checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Rs_ID, Rt_ID, Rt_EX;
    logic        MemRead_EX, Branch_taken_EX;
    logic        PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, pipe_hold;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    hazard_ctrl_if mem_if ();

    hazard_ctrl #(.REG_W(6), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .Rt_EX           (Rt_EX),
        .MemRead_EX      (MemRead_EX),
        .Branch_taken_EX (Branch_taken_EX),
        .mem             (mem_if.slave),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IDEX_bubble     (IDEX_bubble),
        .IFID_flush      (IFID_flush),
        .IDEX_flush      (IDEX_flush),
        .pipe_hold       (pipe_hold),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
    int m_mode = 0;
    int m_wait = 0;
    int m_to   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit mr, input logic [5:0] rt_ex,
                        input logic [5:0] rs, input logic [5:0] rt, input bit br,
                        input bit req, input bit rdy, input bit check);
        bit lu, frz, e_pc, e_ifid, e_bub, e_iff, e_idf, e_hold;
        rst = r; MemRead_EX = mr; Rt_EX = rt_ex; Rs_ID = rs; Rt_ID = rt;
        Branch_taken_EX = br; mem_if.mem_req = req; mem_if.mem_ready = rdy;
        #1;
        lu  = mr && (rt_ex != 0) && (rt_ex == rs || rt_ex == rt);
        frz = (m_mode == 2) || (m_mode == 1 && !rdy) || (m_mode == 0 && req && !rdy);
        e_pc = 1; e_ifid = 1; e_bub = 0; e_iff = 0; e_idf = 0; e_hold = 0;
        if (r || frz) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
        end else if (br) begin
            e_iff = 1; e_idf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
        if (check) begin
            chk("PC_write",    32'(PC_write),    32'(e_pc));
            chk("IFID_write",  32'(IFID_write),  32'(e_ifid));
            chk("IDEX_bubble", 32'(IDEX_bubble), 32'(e_bub));
            chk("IFID_flush",  32'(IFID_flush),  32'(e_iff));
            chk("IDEX_flush",  32'(IDEX_flush),  32'(e_idf));
            chk("pipe_hold",   32'(pipe_hold),   32'(e_hold));
            chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
            chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
            chk("flush_cnt",   32'(flush_cnt),   32'(m_flush));
            chk("state",       32'(state),       32'(m_mode));
        end
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
            if (e_iff) m_flush = (m_flush >= 65535) ? 65535 : m_flush + 1;
            case (m_mode)
                0: if (req && !rdy) begin m_mode = 1; m_wait = 1; end
                1: if (rdy) begin m_mode = 0; m_wait = 0; end else m_wait++;
                default: ;
            endcase
            if (m_mode == 1 && m_wait >= MAX_WAIT) begin m_mode = 2; m_to = 1; end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic reset_pulse();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        // Registers are unknown before the first edge, so the first reset cycle is unchecked.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        idle(2);

        // Load-use on Rs: one bubble cycle, then the bubble clears the hazard.
        step(0, 1, 6'd5, 6'd5, 6'd9, 0, 0, 0, 1);
        idle(1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Register 0 never stalls.
        reset_pulse();
        step(0, 1, 6'd0, 6'd0, 6'd0, 0, 0, 0, 1);
        chk("r0_stall_cnt", 32'(stall_cnt), 32'd0);
        step(0, 1, 6'd7, 6'd1, 6'd7, 0, 0, 0, 1);
        idle(1);

        // Branch flush beats a simultaneous load-use.
        reset_pulse();
        step(0, 1, 6'd3, 6'd3, 6'd3, 1, 0, 0, 1);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory wait of 3 cycles then release.
        reset_pulse();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("mw_state", 32'(state), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("mw_release_state", 32'(state), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

        // Timeout into halt, then recovery by reset.
        reset_pulse();
        for (int i = 0; i < MAX_WAIT; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("to_state", 32'(state), 32'd2);
        chk("to_flag", 32'(mem_timeout), 32'd1);
        step(0, 1, 6'd4, 6'd4, 6'd4, 1, 0, 1, 1);
        reset_pulse();
        chk("to_rst_state", 32'(state), 32'd0);
        chk("to_rst_flag", 32'(mem_timeout), 32'd0);
        chk("to_rst_stall", 32'(stall_cnt), 32'd0);
        chk("to_rst_flush", 32'(flush_cnt), 32'd0);

        // Randomized traffic with small specifier range to provoke hazards.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0), 1);
        end

        // Saturation: halt and let the stall counter run past 16 bits.
        reset_pulse();
        for (int i = 0; i < MAX_WAIT; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 0, 1, 0, (i % 8192) == 0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        reset_pulse();
        chk("sat_rst", 32'(stall_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 6, register-specifier width.
REQ-002 SHALL have parameter MAX_WAIT, default 15, maximum MEM_WAIT cycles before halt (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports Rs_ID, Rt_ID  input  REG_W  source specifiers of the instruction in ID.
REQ-006 SHALL have port Rt_EX  input  REG_W  destination specifier of the load in EX.
REQ-007 SHALL have port MemRead_EX  input  1  EX instruction is a load.
REQ-008 SHALL have port Branch_taken_EX  input  1  branch/jump resolved taken in EX.
REQ-009 SHALL have ports mem_req, mem_ready  input  1 each  MEM-stage data access valid / access complete.
REQ-010 SHALL have ports PC_write, IFID_write  output  1 each  write enables; 1 = advance.
REQ-011 SHALL have ports IDEX_bubble, IFID_flush, IDEX_flush  output  1 each  insert NOP / clear stage.
REQ-012 SHALL have port pipe_hold  output  1  freeze EX/MEM and MEM/WB registers.
REQ-013 SHALL have port mem_timeout  output  1  sticky error flag.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  16 each  performance counters.
REQ-015 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-016 FSM states SHALL be RUN=0, MEM_WAIT=1, HALT=2; encoding 3 is illegal and SHALL go to RUN.
REQ-017 Control outputs SHALL be combinational from state and current inputs; state and counters are registered.
REQ-018 Priority within a cycle SHALL be: freeze (mem wait/halt) > branch flush > load-use stall.
REQ-019 Freeze: PC_write=0, IFID_write=0, pipe_hold=1, IDEX_bubble/IFID_flush/IDEX_flush=0.
REQ-020 RUN with mem_req=1 and mem_ready=0: freeze this cycle; next state MEM_WAIT; wait counter loads 1.
REQ-021 RUN, no freeze, Branch_taken_EX=1: IFID_flush=1, IDEX_flush=1, PC_write=1, IFID_write=1; flush_cnt +1; load-use ignored.
REQ-022 Load-use (RUN, no freeze, no branch, MemRead_EX=1, Rt_EX!=0, Rt_EX==Rs_ID or Rt_EX==Rt_ID): PC_write=0, IFID_write=0, IDEX_bubble=1, exactly one cycle.
REQ-023 Idle (no event): PC_write=1, IFID_write=1, all other control outputs 0.
REQ-024 MEM_WAIT with mem_ready=0: freeze; wait counter +1; when counter equals MAX_WAIT, next state HALT and mem_timeout set.
REQ-025 MEM_WAIT with mem_ready=1: release this cycle (pipe_hold=0), apply REQ-021..023 rules on current inputs, next state RUN.
REQ-026 HALT: freeze every cycle; leaves only via rst; mem_timeout stays 1.
REQ-027 stall_cnt SHALL increment each cycle PC_write=0; both counters saturate at 16'hFFFF.
REQ-028 Specifier 0 SHALL never produce a load-use stall.

Reset
REQ-029 rst=1 at any edge, including mid MEM_WAIT or HALT: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-030 While rst=1, outputs SHALL reflect RUN with idle decode overridden: PC_write=0, IFID_write=0, pipe_hold=1.

Structure
REQ-031 State encodings, REG_W default and counter width SHALL live in shared package cpu_pipe_pkg.
REQ-032 One sub-module hz_sat_cnt (16-bit saturating counter with inc, sync clear) SHALL be instantiated twice.

Verification
REQ-033 MemRead_EX=1, Rt_EX=5, Rs_ID=5 -> one cycle PC_write=0, IDEX_bubble=1, stall_cnt=1.
REQ-034 Same with Rt_EX=0, Rs_ID=0 -> no stall, stall_cnt=0.
REQ-035 Branch_taken_EX=1 with simultaneous load-use -> IFID_flush=IDEX_flush=1, IDEX_bubble=0, flush_cnt=1.
REQ-036 mem_req=1, mem_ready low 3 cycles then high -> pipe_hold=1 for 3 cycles, release on 4th, state MEM_WAIT then RUN, stall_cnt=3.
REQ-037 mem_ready held 0 for 15 cycles -> state=HALT, mem_timeout=1; rst pulse -> RUN, counters 0.
REQ-038 Force 70000 stall cycles -> stall_cnt holds 16'hFFFF.
